// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the multicycle RV32I core.
// Holds the PC and the instruction register. It issues one req/ack read to
// instruction memory per load_instr and reports a stall while the read is
// outstanding.
//
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a fetch that
// gets no ack for TIMEOUT_CYCLES WAIT cycles completes with NOP_INSTR and sets
// the sticky fetch_err flag.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   load_instr            start a fetch at the current PC (ignored in WAIT)
//   inc_pc, sel_addr      PC update: PC+4, or jump_addr with bits [1:0] cleared
//   jump_addr[31:0]       jump target from the ALU
//   imem_req, imem_addr   memory read request and the latched address
//   imem_rdata, imem_ack  memory read data and completion
//   instr, opcode         instruction register and its bits [6:0]
//   pc                    current PC
//   instr_valid           one-cycle pulse when instr is written
//   fetch_stall           high while a fetch is outstanding
//   misalign, fetch_err   sticky flags, cleared only by reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_instr,
  input  logic        inc_pc,
  input  logic        sel_addr,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic        fetch_stall,
  output logic        misalign,
  output logic        fetch_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign opcode = instr[6:0];

  // PC update. This block is independent of the fetch FSM. A fetch already
  // in flight keeps its own latched imem_addr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (inc_pc) begin
      if (sel_addr) begin
        pc <= {jump_addr[31:2], 2'b00};
        if (jump_addr[1:0] != 2'b00) begin
          misalign <= 1'b1;
        end
      end else begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Fetch FSM. It drives the request, the stall and the instruction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_stall <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      instr_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_instr) begin
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            fetch_stall <= 1'b1;
            state       <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        S_WAIT: begin
          // An ack in the timeout cycle still wins and completes the fetch normally.
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            fetch_stall <= 1'b0;
            state       <= S_IDLE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            instr       <= NOP_INSTR;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            fetch_stall <= 1'b0;
            fetch_err   <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef FETCH_TIMEOUT_EN
  assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage for the multicycle RV32I core; sits directly upstream of the control unit and feeds it the opcode.
- Owns the PC and the instruction register.
- Issues a req/ack read to instruction memory when the control unit pulses load_instr.
- Applies PC updates from inc_pc/sel_addr.
- Reports a stall so the control unit can hold the IF state while memory has wait states.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction register value at reset and on fetch error (addi x0,x0,0)
TIMEOUT_CYCLES, 16, max wait cycles for imem_ack (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
load_instr  in  1  start fetch at current PC (control unit, IF state)
inc_pc  in  1  update PC this cycle (control unit, MEM state)
sel_addr  in  1  with inc_pc: take jump_addr instead of PC+4
jump_addr  in  32  jump target from ALU result
imem_req  out  1  memory read request
imem_addr  out  32  memory read address
imem_rdata  in  32  memory read data, valid when imem_ack=1
imem_ack  in  1  read complete
instr  out  32  instruction register
opcode  out  7  instr[6:0]
pc  out  32  current PC
instr_valid  out  1  one-cycle pulse when instr is updated
fetch_stall  out  1  fetch in progress; control unit must not leave IF
misalign  out  1  sticky: jump target had bits [1:0] != 0
fetch_err  out  1  sticky timeout flag (optional feature only, else tied 0)

Behaviour:
- All state uses an asynchronous active-low reset on reset_n, with a rising-edge clk.
- Reset values:
  - pc=RESET_PC, instr=NOP_INSTR
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, fetch_stall=0, misalign=0, fetch_err=0
  - FSM=IDLE
- FSM states IDLE, WAIT:
  - IDLE, load_instr=1: latch imem_addr<=pc, imem_req<=1, fetch_stall<=1, go to WAIT. Request is visible the cycle after load_instr.
  - WAIT, imem_ack=0: hold imem_req, imem_addr and fetch_stall.
  - WAIT, imem_ack=1: instr<=imem_rdata, instr_valid<=1 for one cycle, imem_req<=0, fetch_stall<=0, go to IDLE.
  - Minimum latency from load_instr to instr_valid is 2 cycles (ack in the first WAIT cycle). Each extra wait cycle adds 1.
- load_instr while in WAIT: ignored. No second request is queued.
- imem_ack while in IDLE: ignored. instr is unchanged.
- PC update:
  - inc_pc=1, sel_addr=0: pc<=pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - inc_pc=1, sel_addr=1: pc<={jump_addr[31:2],2'b00}. If jump_addr[1:0]!=0, set misalign.
  - inc_pc=0: sel_addr has no effect.
- PC updates are legal in any FSM state. An in-flight fetch keeps its latched imem_addr; a PC change during WAIT does not alter the outstanding request.
- misalign and fetch_err clear only on reset.
- opcode is combinational from instr[6:0].
- Reset asserted mid-fetch: imem_req drops immediately (asynchronous). A late imem_ack after reset release is ignored because the FSM is in IDLE.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter starts at 0 on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: instr<=NOP_INSTR, instr_valid pulses, fetch_err<=1, imem_req<=0, fetch_stall<=0, FSM returns to IDLE.
  - An ack in the same cycle as the timeout wins: normal capture, no error.
- Undefined: no counter; WAIT holds indefinitely; fetch_err is tied 0.

Test Plan:
- Reset then load_instr, memory acks 1 cycle after req with rdata=32'h00500093 -> imem_addr=0; instr=32'h00500093; opcode=7'h13; instr_valid pulses 2 cycles after load_instr; fetch_stall high for exactly 1 cycle.
- Memory inserts 3 wait cycles -> fetch_stall high 4 cycles, imem_addr stable throughout, instr updates only on the ack cycle.
- pc=0xFFFF_FFFC, inc_pc=1, sel_addr=0 -> pc=0x0000_0000.
- inc_pc=1, sel_addr=1, jump_addr=0x0000_0102 -> pc=0x0000_0100, misalign=1, held until reset.
- During WAIT (imem_addr=0x10): inc_pc=1, then a second load_instr -> pc=0x14, imem_addr stays 0x10, only one ack consumed, no second request.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> after 16 WAIT cycles instr=32'h00000013, fetch_err=1, imem_req=0. Separately, reset_n pulsed low mid-WAIT -> imem_req=0 at once, pc=RESET_PC.
